// File: rtl/bcd_to_bin_if.sv
// Handshake/result bundle for the sequential BCD-to-binary decoder.
// The master drives the request and the slave returns status and result.
interface bcd_to_bin_if #(
    parameter int NDIG  = 3,
    parameter int MAG_W = 10
);
    logic                  START;
    logic [4*NDIG-1:0]     BCD_IN;
    logic                  SIGN_IN;
    logic                  BUSY;
    logic                  DONE;
    logic [MAG_W:0]        BIN_OUT;
    logic                  ERR;
    logic                  OVF;

    modport master (
        output START, BCD_IN, SIGN_IN,
        input  BUSY, DONE, BIN_OUT, ERR, OVF
    );

    modport slave (
        input  START, BCD_IN, SIGN_IN,
        output BUSY, DONE, BIN_OUT, ERR, OVF
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Signed BCD to two's-complement decoder, one digit per cycle, MSD first.
// Optional macro BCD2BIN_SAT9_EN clamps the result to -256..+255 and flags OVF.
module bcd_to_bin_seq #(
    parameter int NDIG  = 3,
    parameter int MAG_W = 10
) (
    input  logic         CLK,
    input  logic         RST,
    bcd_to_bin_if.slave  bus
);
    localparam int BIN_W = MAG_W + 1;
    localparam int CNT_W = $clog2(NDIG + 1);
    localparam int SR_W  = 4 * NDIG;

    typedef enum logic [1:0] {IDLE, CONV, FINAL} state_t;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sreg_q, sreg_d;
    logic               sign_q, sign_d;
    logic               inv_q, inv_d;
    logic [MAG_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;
    logic               ovf_q, ovf_d;

    logic [NDIG-1:0]    nib_bad;
    logic [BIN_W-1:0]   mag_ext;
    logic [BIN_W-1:0]   signed_res;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_nib_chk
            assign nib_bad[gi] = (bus.BCD_IN[4*gi +: 4] > 4'd9);
        end
    endgenerate

    // Zero magnitude negates to zero, so no negative zero can appear.
    assign mag_ext    = {1'b0, acc_q};
    assign signed_res = sign_q ? (~mag_ext + 1'b1) : mag_ext;

`ifdef BCD2BIN_SAT9_EN
    localparam logic [BIN_W-1:0] SAT_MIN = BIN_W'(-32'sd256);
    localparam logic [BIN_W-1:0] SAT_MAX = BIN_W'(32'sd255);
    logic [31:0] acc_wide;
    assign acc_wide = 32'(acc_q);
`endif

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        sign_d  = sign_q;
        inv_d   = inv_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bin_d   = bin_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    sreg_d  = bus.BCD_IN;
                    sign_d  = bus.SIGN_IN;
                    inv_d   = |nib_bad;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                // acc*10 as acc*8 + acc*2; cannot wrap given 2^MAG_W > 10^NDIG-1
                acc_d  = (acc_q << 3) + (acc_q << 1) + MAG_W'(sreg_q[SR_W-1 -: 4]);
                sreg_d = sreg_q << 4;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NDIG - 1)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (inv_q) begin
                    bin_d = '0;
                    err_d = 1'b1;
                    ovf_d = 1'b0;
                end else begin
                    err_d = 1'b0;
`ifdef BCD2BIN_SAT9_EN
                    if (sign_q && (acc_wide > 32'd256)) begin
                        bin_d = SAT_MIN;
                        ovf_d = 1'b1;
                    end else if (!sign_q && (acc_wide > 32'd255)) begin
                        bin_d = SAT_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        bin_d = signed_res;
                        ovf_d = 1'b0;
                    end
`else
                    bin_d = signed_res;
                    ovf_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            sign_q  <= 1'b0;
            inv_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            sign_q  <= sign_d;
            inv_q   <= inv_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.BIN_OUT = bin_q;
    assign bus.ERR     = err_q;
    assign bus.OVF     = ovf_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: scoreboard of expected results, checked on DONE.
// Expected values come from an integer decimal model, clamped when BCD2BIN_SAT9_EN is set.
module tb_bcd_to_bin_seq;
    localparam int NDIG  = 3;
    localparam int MAG_W = 10;
    localparam int BIN_W = MAG_W + 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    bcd_to_bin_if #(.NDIG(NDIG), .MAG_W(MAG_W)) bus ();

    bcd_to_bin_seq #(.NDIG(NDIG), .MAG_W(MAG_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
        logic             ovf;
        int               acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   pushed   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [11:0] bcd, input logic s);
        exp_t r;
        int   mag;
        int   v;
        bit   bad;
        mag = 0;
        bad = 0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            int d;
            d = int'((bcd >> (4 * i)) & 12'hF);
            if (d > 9) bad = 1;
            mag = mag * 10 + d;
        end
        v = s ? -mag : mag;
        r.ovf = 1'b0;
`ifdef BCD2BIN_SAT9_EN
        if (v > 255) begin
            v = 255;
            r.ovf = 1'b1;
        end else if (v < -256) begin
            v = -256;
            r.ovf = 1'b1;
        end
`endif
        r.err = bad;
        if (bad) begin
            v = 0;
            r.ovf = 1'b0;
        end
        r.bin = BIN_W'(v);
        r.acc_cyc = 0;
        return r;
    endfunction

    always @(negedge CLK) begin
        if (!RST && bus.DONE) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bin_out", 32'(bus.BIN_OUT), 32'(e.bin));
                chk("err", 32'(bus.ERR), 32'(e.err));
                chk("ovf", 32'(bus.OVF), 32'(e.ovf));
                chk("latency", 32'(cyc - e.acc_cyc), 32'(NDIG + 1));
                $display("[TB] done bin=%0h err=%0b ovf=%0b", bus.BIN_OUT, bus.ERR, bus.OVF);
            end
        end
    end

    task automatic issue(input logic [11:0] bcd, input logic s, input bit expect_done);
        exp_t e;
        bus.START   = 1'b1;
        bus.BCD_IN  = bcd;
        bus.SIGN_IN = s;
        @(posedge CLK); #1;
        if (expect_done) begin
            e = model(bcd, s);
            e.acc_cyc = cyc;
            sb.push_back(e);
            pushed++;
        end
        $display("[TB] start bcd=%03h sign=%0b", bcd, s);
        bus.START   = 1'b0;
        bus.BCD_IN  = 12'($urandom);
        bus.SIGN_IN = 1'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge CLK); #1;
    endtask

    initial begin
        int d0;
        bus.START   = 1'b0;
        bus.BCD_IN  = '0;
        bus.SIGN_IN = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_bin", 32'(bus.BIN_OUT), 32'd0);
        chk("rst_err", 32'(bus.ERR), 32'd0);
        chk("rst_ovf", 32'(bus.OVF), 32'd0);
        @(posedge CLK); #1;

        // 255 positive with BUSY/DONE timing
        issue(12'h255, 1'b0, 1'b1);
        for (int i = 0; i < NDIG + 1; i++) begin
            @(negedge CLK);
            chk("busy_high", 32'(bus.BUSY), 32'd1);
            chk("done_low", 32'(bus.DONE), 32'd0);
        end
        @(negedge CLK);
        chk("busy_fall", 32'(bus.BUSY), 32'd0);
        chk("done_pulse", 32'(bus.DONE), 32'd1);
        drain();
        chk("done_one_cycle", 32'(bus.DONE), 32'd0);

        issue(12'h128, 1'b1, 1'b1); drain();
        issue(12'h000, 1'b1, 1'b1); drain();
        issue(12'h1A3, 1'b0, 1'b1); drain();
        issue(12'h007, 1'b0, 1'b1); drain();

        // START during busy is ignored
        d0 = done_cnt;
        issue(12'h042, 1'b0, 1'b1);
        @(posedge CLK); #1;
        bus.START  = 1'b1;
        bus.BCD_IN = 12'h777;
        repeat (2) @(posedge CLK);
        #1 bus.START = 1'b0;
        drain();
        repeat (6) @(posedge CLK);
        #1 chk("busy_start_one_done", 32'(done_cnt - d0), 32'd1);

        // START held through DONE: second request accepted in the DONE cycle
        begin
            exp_t e;
            bus.START   = 1'b1;
            bus.BCD_IN  = 12'h063;
            bus.SIGN_IN = 1'b1;
            @(posedge CLK); #1;
            e = model(12'h063, 1'b1); e.acc_cyc = cyc; sb.push_back(e); pushed++;
            bus.BCD_IN  = 12'h210;
            bus.SIGN_IN = 1'b0;
            repeat (NDIG + 1) @(posedge CLK);
            @(posedge CLK); #1;
            e = model(12'h210, 1'b0); e.acc_cyc = cyc; sb.push_back(e); pushed++;
            bus.START = 1'b0;
            $display("[TB] back-to-back 063- then 210+");
            drain();
        end

        // Reset mid-conversion aborts without DONE
        d0 = done_cnt;
        issue(12'h999, 1'b0, 1'b0);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        chk("abort_busy", 32'(bus.BUSY), 32'd0);
        chk("abort_done", 32'(bus.DONE), 32'd0);
        chk("abort_bin", 32'(bus.BIN_OUT), 32'd0);
        chk("abort_err", 32'(bus.ERR), 32'd0);
        repeat (8) @(posedge CLK);
        #1 chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        $display("[TB] reset abort of 999");

        issue(12'h999, 1'b1, 1'b1); drain();
        issue(12'h300, 1'b0, 1'b1); drain();
        issue(12'h256, 1'b1, 1'b1); drain();
        issue(12'h257, 1'b1, 1'b1); drain();
        issue(12'h9F0, 1'b1, 1'b1); drain();

        for (int n = 0; n < 6; n++) begin
            logic [11:0] v;
            v = {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
            issue(v, 1'($urandom), 1'b1);
            drain();
        end

        chk("done_total", 32'(done_cnt), 32'(pushed));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
